// File: rtl/i2s_clkgen.sv
// I2S master clock generator: SCK/WS with frame-aligned start, drain and
// configuration updates.
module i2s_clkgen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [5:0]           wlen_i,
    output logic                 busy_o,
    output logic                 i2s_sck_o,
    output logic                 i2s_ws_o,
    output logic                 sck_rise_o,
    output logic                 sck_fall_o,
    output logic                 frame_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_hcnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [5:0]           r_bcnt;
    logic [5:0]           r_wlen;
    logic                 r_sck;
    logic                 r_ws;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_frame;

    logic [5:0]           w_wlen_clamped;
    logic                 w_tick;
    logic                 w_fall_tick;
    logic                 w_word_end;
    logic                 w_boundary;

    always_comb begin
        w_wlen_clamped = wlen_i;
        if (wlen_i < 6'd2)
            w_wlen_clamped = 6'd2;
        else if (wlen_i > 6'd32)
            w_wlen_clamped = 6'd32;
    end

    assign w_tick      = (r_state != IDLE) && (r_hcnt == r_div);
    assign w_fall_tick = w_tick && r_sck;
    assign w_word_end  = w_fall_tick && (r_bcnt == r_wlen - 6'd1);
    // A right-word end is the frame boundary
    assign w_boundary  = w_word_end && r_ws;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_hcnt  <= '0;
            r_div   <= '0;
            r_bcnt  <= '0;
            r_wlen  <= '0;
            r_sck   <= 1'b0;
            r_ws    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_frame <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en_i) begin
                        r_state <= RUN;
                        r_div   <= div_i;
                        r_wlen  <= w_wlen_clamped;
                    end
                end
                RUN, DRAIN: begin
                    r_hcnt  <= w_tick ? '0 : r_hcnt + 1'b1;
                    r_rise  <= w_tick && !r_sck;
                    r_fall  <= w_fall_tick;
                    r_state <= en_i ? RUN : DRAIN;
                    if (w_tick)
                        r_sck <= ~r_sck;
                    if (w_fall_tick)
                        r_bcnt <= w_word_end ? 6'd0 : r_bcnt + 6'd1;
                    if (w_word_end)
                        r_ws <= ~r_ws;
                    if (w_boundary) begin
                        r_frame <= 1'b1;
                        r_div   <= div_i;
                        r_wlen  <= w_wlen_clamped;
                        // Counters and SCK/WS already land at zero here
                        if (r_state == DRAIN && !en_i)
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o     = (r_state != IDLE);
    assign i2s_sck_o  = r_sck;
    assign i2s_ws_o   = r_ws;
    assign sck_rise_o = r_rise;
    assign sck_fall_o = r_fall;
    assign frame_o    = r_frame;

endmodule

// File: tb/tb_i2s_clkgen.sv
// Randomized bench for i2s_clkgen against a frame-position reference model.
module tb_i2s_clkgen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] div = '0;
    logic [5:0]  wlen = '0;
    logic        busy, sck, ws, rise, fall, frame;
    logic [5:0]  w_outs;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position inside the current frame plus its config
    bit         m_act = 0;
    bit         m_stop = 0;
    bit         m_first = 0;
    int         m_p = 0;
    int         m_d = 0;
    int         m_w = 2;
    logic [5:0] m_exp = '0;

    int wtab[8] = '{0, 1, 2, 8, 16, 24, 40, 63};

    i2s_clkgen #(.DIV_WIDTH(16)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .div_i      (div),
        .wlen_i     (wlen),
        .busy_o     (busy),
        .i2s_sck_o  (sck),
        .i2s_ws_o   (ws),
        .sck_rise_o (rise),
        .sck_fall_o (fall),
        .frame_o    (frame)
    );

    assign w_outs = {busy, sck, ws, rise, fall, frame};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got %b expected %b",
                         tag, $time, got[5:0], exp[5:0]);
        end
    endtask

    function automatic int clampw(input int x);
        if (x < 2) return 2;
        if (x > 32) return 32;
        return x;
    endfunction

    task automatic model_reset();
        m_act = 0;
        m_stop = 0;
        m_p = 0;
        m_exp = '0;
    endtask

    task automatic model_step();
        bit fin;
        int h;
        fin = 0;
        if (!m_act) begin
            if (en) begin
                m_act = 1;
                m_p = 0;
                m_d = int'(div);
                m_w = clampw(int'(wlen));
                m_first = 1;
                m_stop = 0;
            end
        end else begin
            m_p++;
            if (m_p == 4 * m_w * (m_d + 1)) begin
                if (m_stop && !en) begin
                    m_act = 0;
                    fin = 1;
                end else begin
                    m_p = 0;
                    m_d = int'(div);
                    m_w = clampw(int'(wlen));
                    m_first = 0;
                end
            end
            m_stop = !en;
        end
        if (!m_act) begin
            m_exp = {4'b0000, fin, fin};
        end else begin
            h = m_d + 1;
            m_exp[5] = 1'b1;
            m_exp[4] = ((m_p / h) % 2) == 1;
            m_exp[3] = m_p >= 2 * m_w * h;
            m_exp[2] = (m_p % (2 * h)) == h;
            m_exp[1] = ((m_p % (2 * h)) == 0) && !(m_p == 0 && m_first);
            m_exp[0] = (m_p == 0) && !m_first;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n)
            model_reset();
        else
            model_step();
        #1;
        chk("outs", {26'd0, w_outs}, {26'd0, m_exp});
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst", {26'd0, w_outs}, 32'd0);
        tick();
        rst_n = 1'b1;
        en = 1'b0;
        div = 16'($urandom_range(0, 3));
        wlen = 6'($urandom_range(0, 63));
        repeat (6) tick();
    endtask

    initial begin
        int mode, hold, rst_at, n;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        for (int s = 0; s < 32; s++) begin
            mode = $urandom_range(0, 4);
            div  = 16'($urandom_range(0, 3));
            wlen = 6'(wtab[$urandom_range(0, 7)]);
            en   = 1'b1;
            if (mode == 0) begin
                tick();
                en = 1'b0;
            end else begin
                hold   = $urandom_range(1, 500);
                rst_at = (mode == 3) ? $urandom_range(1, hold) : -1;
                for (int c = 0; c < hold; c++) begin
                    tick();
                    if (c == rst_at) begin
                        do_reset();
                        break;
                    end
                    if ($urandom_range(0, 40) == 0) begin
                        div  = 16'($urandom_range(0, 3));
                        wlen = 6'(wtab[$urandom_range(0, 7)]);
                    end
                    if (mode == 4 && $urandom_range(0, 30) == 0)
                        en = ~en;
                end
                en = 1'b0;
            end
            n = 0;
            while (m_act && n < 3000) begin
                tick();
                n++;
            end
            chk("drain_done", {31'd0, busy}, 32'd0);
            for (int c = 0; c < 5; c++) begin
                div  = 16'($urandom_range(0, 3));
                wlen = 6'($urandom_range(0, 63));
                tick();
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_clkgen.md
I2S_CLKGEN -- requirements
Module: i2s_clkgen

Interface
REQ-001 Parameter DIV_WIDTH, default 16, sets the width of the half-period divider input.
REQ-002 Port clk_i, input, 1: system clock; all logic is on its rising edge.
REQ-003 Port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-004 Port en_i, input, 1: level enable that requests SCK/WS generation.
REQ-005 Port div_i, input, DIV_WIDTH: SCK half-period minus one, in clk_i cycles.
REQ-006 Port wlen_i, input, 6: bits per channel word.
REQ-007 Port busy_o, output, 1: high whenever the state is not IDLE.
REQ-008 Port i2s_sck_o, output, 1: registered bit clock, driving the core's i2s_sck_i.
REQ-009 Port i2s_ws_o, output, 1: registered word select (0 = left, 1 = right), driving the core's i2s_ws_i.
REQ-010 Port sck_rise_o, output, 1: one-cycle pulse in the first clk_i cycle that i2s_sck_o is high.
REQ-011 Port sck_fall_o, output, 1: one-cycle pulse in the first clk_i cycle that i2s_sck_o is low after being high.
REQ-012 Port frame_o, output, 1: one-cycle pulse coincident with the sck_fall_o that moves i2s_ws_o from 1 to 0.

Function
REQ-013 The block shall implement three states: IDLE, RUN and DRAIN.
REQ-014 In IDLE, i2s_sck_o, i2s_ws_o, all pulses, the half-period counter and the bit counter shall be 0.
REQ-015 IDLE -> RUN when en_i=1 is sampled; in the same edge, div_i and the clamped wlen_i are latched into the active configuration.
REQ-016 Clamp rule: wlen_i<2 is used as 2, wlen_i>32 is used as 32, and other values are used unchanged.
REQ-017 In RUN/DRAIN, the half-period counter increments each cycle; when it equals latched div, it returns to 0 and i2s_sck_o toggles on that edge.
REQ-018 SCK timing: the first i2s_sck_o rise is registered div+1 cycles after entering RUN, and the SCK period is 2*(div+1) cycles; div=0 gives clk_i/2.
REQ-019 The bit counter shall increment on each SCK falling toggle.
REQ-020 When the bit counter equals wlen-1 on a falling toggle, it wraps to 0 and i2s_ws_o toggles on the same edge.
REQ-021 i2s_ws_o shall change only coincident with SCK falling toggles.
REQ-022 On each WS 1->0 toggle (frame boundary), the active configuration shall be re-latched from div_i/wlen_i.
REQ-023 div_i/wlen_i changes mid-frame shall have no effect until the next frame boundary.
REQ-024 RUN -> DRAIN when en_i=0 is sampled.
REQ-025 DRAIN -> RUN when en_i=1 is sampled before the frame boundary; the frame continues unbroken.
REQ-026 In DRAIN, generation continues until the next frame boundary; on that edge the state becomes IDLE with i2s_sck_o=0 and i2s_ws_o=0.
REQ-027 The frame_o/sck_fall_o pulses of that final boundary edge shall still be issued.
REQ-028 Stopping shall never truncate a stereo frame: every frame shall contain 2*wlen full SCK periods.
REQ-029 en_i=1 in IDLE with en_i toggling for one cycle only shall still produce exactly one complete frame.
REQ-030 busy_o shall be a function of the registered state only.

Reset
REQ-031 Asserting rst_n_i shall immediately force IDLE, all outputs to 0, all counters to 0, and the latched configuration to 0, regardless of activity, including mid-frame.
REQ-032 After rst_n_i deasserts, no output shall change until en_i=1 is sampled.

Verification
REQ-033 Scenario: en_i=1, div_i=1, wlen_i=16 -> SCK period 4 cycles, WS period 128 cycles, first sck_rise_o 2 cycles after RUN, and frame_o every 128 cycles.
REQ-034 Scenario: div_i=0, wlen_i=8 with en_i held -> SCK toggles every cycle, and i2s_ws_o toggles every 16 cycles on falling toggles only.
REQ-035 Scenario: en_i dropped at bit 3 of the left word (wlen=16, div=2) -> the right word completes, busy_o falls on the 1->0 WS edge, and exactly 32 SCK rises occur in that frame.
REQ-036 Scenario: wlen_i=40 and then wlen_i=1 -> frames of 32 and 2 bits per channel respectively.
REQ-037 Scenario: wlen_i changed 16->24 mid-frame -> the current frame keeps 16 bits/channel and the next frame uses 24.
REQ-038 Scenario: rst_n_i pulsed low mid-RUN -> outputs are 0 asynchronously; after release, the block stays IDLE until en_i=1.
